// File: rtl/move_arbiter.sv
// Arbitrates button and accelerometer move requests into single-cycle
// move pulses, with a button repeat tick and a post-move cooldown.
module move_arbiter #(
    parameter int unsigned TICK_DIV   = 1111110,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn_dir,
    input  logic [3:0]  accel_pulse,
    input  logic [1:0]  src_sel,
    input  logic        enable,
    output logic [3:0]  move_out,
    output logic        active_src,
    output logic [15:0] move_count
);

    localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES - 1);

    typedef enum logic {
        IDLE,
        COOLDOWN
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [GW-1:0]   cool_cnt_q, cool_cnt_d;
    logic [3:0]      pend_q, pend_d;
    logic [3:0]      move_q, move_d;
    logic            src_q, src_d;
    logic [15:0]     count_q, count_d;

    logic            tick;
    logic [3:0]      btn_eff;
    logic [3:0]      pend_eff;
    logic            btn_ok;
    logic            acc_ok;
    logic            btn_issue;
    logic            acc_issue;
    logic            pend_clr;

    // Opposite directions on one axis cancel each other out.
    function automatic logic [3:0] axis_cancel(input logic [3:0] v);
        logic [3:0] r;
        r = v;
        if (&v[3:2]) r[3:2] = 2'b00;
        if (&v[1:0]) r[1:0] = 2'b00;
        return r;
    endfunction

    always_comb begin
        tick       = (tick_cnt_q == TICK_MAX);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        btn_eff    = axis_cancel(btn_dir);
        pend_eff   = axis_cancel(pend_q);
        btn_ok     = (src_sel == 2'b00) || (src_sel == 2'b01);
        acc_ok     = (src_sel == 2'b00) || (src_sel == 2'b10);
        btn_issue  = (state_q == IDLE) && btn_ok && tick && (|btn_eff);
        acc_issue  = (state_q == IDLE) && acc_ok && (|pend_eff)
                     && !btn_issue
                     && !((src_sel == 2'b00) && (|btn_eff));
    end

    always_comb begin
        state_d    = state_q;
        cool_cnt_d = cool_cnt_q;
        move_d     = 4'b0000;
        src_d      = src_q;
        count_d    = count_q;
        pend_clr   = 1'b0;
        if (!enable) begin
            state_d    = IDLE;
            cool_cnt_d = '0;
            pend_clr   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (btn_issue) begin
                        move_d     = btn_eff;
                        src_d      = 1'b0;
                        count_d    = count_q + 16'd1;
                        pend_clr   = 1'b1;
                        state_d    = COOLDOWN;
                        cool_cnt_d = '0;
                    end else if (acc_issue) begin
                        move_d     = pend_eff;
                        src_d      = 1'b1;
                        count_d    = count_q + 16'd1;
                        pend_clr   = 1'b1;
                        state_d    = COOLDOWN;
                        cool_cnt_d = '0;
                    end
                end
                COOLDOWN: begin
                    if (cool_cnt_q == GAP_MAX) begin
                        state_d    = IDLE;
                        cool_cnt_d = '0;
                    end else begin
                        cool_cnt_d = cool_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (src_sel == 2'b11 || src_sel == 2'b01) pend_clr = 1'b1;
        // A new pulse survives a clear in the same cycle.
        pend_d = (pend_clr ? 4'b0000 : pend_q) | accel_pulse;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            cool_cnt_q <= '0;
            pend_q     <= 4'b0000;
            move_q     <= 4'b0000;
            src_q      <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            cool_cnt_q <= cool_cnt_d;
            pend_q     <= pend_d;
            move_q     <= move_d;
            src_q      <= src_d;
            count_q    <= count_d;
        end
    end

    wire [15:0] move_count_q = count_q;

    assign move_out   = move_q;
    assign active_src = src_q;
    assign move_count = move_count_q;

endmodule
